jpeg_bitstream_reader: RTL
==========================

Name: jpeg_bitstream_reader

Overview:
Entropy-coded-segment front end for the JPEG decoder path. It takes the byte stream produced by the encoder's bit writer and file generator, strips 0xFF00 byte stuffing, skips 0xFF fill bytes, and detects markers. It keeps an MSB-aligned bit buffer and presents a peek window plus a variable-length consume port to the downstream Huffman decoder.

Parameters:
BUF_WIDTH  32  bit buffer width; multiple of 8; must be >= PEEK_WIDTH+8
PEEK_WIDTH  16  width of peek window; also the maximum consume length

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
s_axis_tdata  in  8  JPEG byte stream
s_axis_tvalid  in  1  byte valid
s_axis_tready  out  1  byte accepted when tvalid&&tready
s_axis_tlast  in  1  last byte of stream
s_axis_tuser  in  1  first byte of frame; clears buffer state before the byte is processed
bits_peek  out  PEEK_WIDTH  buf[BUF_WIDTH-1 -: PEEK_WIDTH]; bits below level read as 1
bits_level  out  $clog2(BUF_WIDTH+1)  number of valid bits in buffer
consume_valid  in  1  consume request
consume_len  in  $clog2(PEEK_WIDTH+1)  bits to drop, 1..PEEK_WIDTH
align_req  in  1  discard (level mod 8) bits (byte-align for RSTn)
marker_valid  out  1  marker detected; held until marker_ack
marker_code  out  8  second byte of marker (e.g. 0xD9 = EOI)
marker_ack  in  1  release marker hold
end_of_stream  out  1  sticky; set when tlast byte is accepted
underflow_err  out  1  sticky; consume_len > bits_level seen

Behaviour:
- Reset (async, rst_n=0) sets: buffer all ones, level 0, state NORMAL, marker_valid 0, marker_code 0x00, end_of_stream 0, underflow_err 0. s_axis_tready is combinational and reads 1 after reset.
- s_axis_tready = (state != MARKER_HOLD) && (bits_level <= BUF_WIDTH-8). It does not depend on consume in the same cycle.
- States:
  - NORMAL: accepting 0xFF → GOT_FF, nothing appended. Any other byte → appended.
  - GOT_FF: 0x00 → append 0xFF, → NORMAL. 0xFF → stay in GOT_FF (fill byte). Any other byte b → marker_code=b, marker_valid=1, → MARKER_HOLD.
  - MARKER_HOLD: tready=0. marker_ack → marker_valid=0, → NORMAL. consume and align remain legal in this state.
- Per-cycle update order: consume, then align, then append.
  - l1 = level - (consume_valid ? consume_len : 0).
  - Shift buf left by consume_len; shift ones in at the LSBs.
  - Align: l2 = l1 - (l1 mod 8), shift applied likewise.
  - Append: byte written to buf[BUF_WIDTH-1-l2 -: 8], level = l2+8.
  - Simultaneous consume and accept is legal; the tready condition guarantees no overflow.
- Underflow: if consume_len > level, consume only level bits, set underflow_err, and keep running. consume_len=0 is a no-op.
- Latency: a byte accepted at edge N is visible in bits_peek/bits_level after edge N. A consume at edge N is reflected after edge N. A marker byte accepted at edge N gives marker_valid=1 after edge N.
- tuser on an accepted byte: level=0, buffer ones, state NORMAL, marker_valid=0, both sticky flags cleared; then the byte is processed normally.
- tlast: sets end_of_stream. A pending GOT_FF state at tlast is discarded (state → NORMAL).
- marker_ack while not in MARKER_HOLD is ignored.

Test Plan:
1. Reset, then bytes 0xA5,0x3C, no consume → level=16, bits_peek=0xA53C; consume_len=4 → level=12, peek=0x53CF.
2. Bytes 0x12,0xFF,0x00,0x34 → level=24, buffer top 24 bits = 0x12FF34; stuffing byte dropped.
3. Bytes 0xFF,0xFF,0xFF,0xD9 → no bits appended, marker_valid=1, marker_code=0xD9, tready=0 until marker_ack, then tready=1 next cycle.
4. Fill to level=32 with 0x01..0x04 → tready=0. Consume 8 while byte 0x05 is offered: not accepted that cycle, accepted next (level 24→32), peek=0x0203.
5. Level 12 after consuming 12 of 0xAB,0xCD,0xEF; align_req → level=8, peek=0xEFFF. Then consume_len=10 at level 8 → level 0, underflow_err=1.
6. Reset asserted mid-stream while marker_valid=1 and level=20 → all outputs return to reset values immediately, asynchronously.

Source files
------------

// File: rtl/jpeg_bitstream_reader.sv
// JPEG entropy-coded segment reader: removes 0xFF00 stuffing, skips fill bytes,
// holds on markers, and feeds an MSB-aligned bit buffer to the Huffman decoder.
module jpeg_bitstream_reader #(
  parameter int BUF_WIDTH  = 32,
  parameter int PEEK_WIDTH = 16,
  localparam int LW = $clog2(BUF_WIDTH + 1),
  localparam int CW = $clog2(PEEK_WIDTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [7:0]            s_axis_tdata,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  input  logic                  s_axis_tlast,
  input  logic                  s_axis_tuser,
  output logic [PEEK_WIDTH-1:0] bits_peek,
  output logic [LW-1:0]         bits_level,
  input  logic                  consume_valid,
  input  logic [CW-1:0]         consume_len,
  input  logic                  align_req,
  output logic                  marker_valid,
  output logic [7:0]            marker_code,
  input  logic                  marker_ack,
  output logic                  end_of_stream,
  output logic                  underflow_err
);

  typedef enum logic [1:0] {
    NORMAL      = 2'd0,
    GOT_FF      = 2'd1,
    MARKER_HOLD = 2'd2
  } state_t;

  localparam logic [BUF_WIDTH-1:0] ONES     = {BUF_WIDTH{1'b1}};
  localparam logic [BUF_WIDTH-1:0] TOP_BYTE = {8'hFF, {(BUF_WIDTH-8){1'b0}}};

  state_t               state_q, state_d;
  logic [BUF_WIDTH-1:0] buf_q, buf_d;
  logic [LW-1:0]        level_q, level_d;
  logic                 marker_valid_q, marker_valid_d;
  logic [7:0]           marker_code_q, marker_code_d;
  logic                 eos_q, eos_d;
  logic                 uf_q, uf_d;
  logic                 accept_s;
  logic                 append_s;
  logic [7:0]           app_byte_s;
  logic [LW-1:0]        drop_s;

  assign s_axis_tready = (state_q != MARKER_HOLD) && (level_q <= LW'(BUF_WIDTH - 8));
  assign accept_s      = s_axis_tvalid && s_axis_tready;

  // Next-state: frame clear, consume, align, marker release, then byte append.
  always_comb begin
    state_d        = state_q;
    buf_d          = buf_q;
    level_d        = level_q;
    marker_valid_d = marker_valid_q;
    marker_code_d  = marker_code_q;
    eos_d          = eos_q;
    uf_d           = uf_q;
    append_s       = 1'b0;
    app_byte_s     = s_axis_tdata;
    drop_s         = '0;

    if (accept_s && s_axis_tuser) begin
      // A new frame discards everything, including any same-cycle consume.
      state_d        = NORMAL;
      buf_d          = ONES;
      level_d        = '0;
      marker_valid_d = 1'b0;
      eos_d          = 1'b0;
      uf_d           = 1'b0;
    end else begin
      if (consume_valid && (consume_len != '0)) begin
        if (LW'(consume_len) > level_d) begin
          drop_s = level_d;
          uf_d   = 1'b1;
        end else begin
          drop_s = LW'(consume_len);
        end
        buf_d   = (buf_d << drop_s) | ~(ONES << drop_s);
        level_d = level_d - drop_s;
      end else begin
        drop_s = '0;
      end
      if (align_req) begin
        buf_d   = (buf_d << level_d[2:0]) | ~(ONES << level_d[2:0]);
        level_d = level_d - LW'(level_d[2:0]);
      end else begin
        level_d = level_d;
      end
    end

    if ((state_q == MARKER_HOLD) && marker_ack) begin
      marker_valid_d = 1'b0;
      state_d        = NORMAL;
    end else begin
      marker_valid_d = marker_valid_d;
    end

    if (accept_s) begin
      case (state_d)
        NORMAL: begin
          if (s_axis_tdata == 8'hFF) begin
            state_d = GOT_FF;
          end else begin
            append_s = 1'b1;
          end
        end
        GOT_FF: begin
          if (s_axis_tdata == 8'h00) begin
            append_s   = 1'b1;
            app_byte_s = 8'hFF;
            state_d    = NORMAL;
          end else if (s_axis_tdata == 8'hFF) begin
            state_d = GOT_FF;
          end else begin
            marker_code_d  = s_axis_tdata;
            marker_valid_d = 1'b1;
            state_d        = MARKER_HOLD;
          end
        end
        default: state_d = state_d;
      endcase
      if (s_axis_tlast) begin
        eos_d = 1'b1;
        if (state_d == GOT_FF) begin
          state_d = NORMAL;
        end else begin
          state_d = state_d;
        end
      end else begin
        eos_d = eos_d;
      end
    end else begin
      append_s = 1'b0;
    end

    if (append_s) begin
      buf_d   = (buf_d & ~(TOP_BYTE >> level_d)) | ({app_byte_s, {(BUF_WIDTH-8){1'b0}}} >> level_d);
      level_d = level_d + LW'(8);
    end else begin
      level_d = level_d;
    end
  end

  // State and buffer registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= NORMAL;
      buf_q          <= ONES;
      level_q        <= '0;
      marker_valid_q <= 1'b0;
      marker_code_q  <= 8'h00;
      eos_q          <= 1'b0;
      uf_q           <= 1'b0;
    end else begin
      state_q        <= state_d;
      buf_q          <= buf_d;
      level_q        <= level_d;
      marker_valid_q <= marker_valid_d;
      marker_code_q  <= marker_code_d;
      eos_q          <= eos_d;
      uf_q           <= uf_d;
    end
  end

  assign bits_peek     = buf_q[BUF_WIDTH-1 -: PEEK_WIDTH];
  assign bits_level    = level_q;
  assign marker_valid  = marker_valid_q;
  assign marker_code   = marker_code_q;
  assign end_of_stream = eos_q;
  assign underflow_err = uf_q;

endmodule
